// File: rtl/rf_write_arbiter.sv
// Register-file writeback arbiter: picks one of two writeback requesters per
// cycle, registers the winning write onto the register-file write port, and
// keeps a per-register pending scoreboard for source-operand hazard checks.
module rf_write_arbiter (
  input  logic        clk,
  input  logic        rst,
  // requester A (ALU path)
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  // requester B (load / multi-cycle path)
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  // destination reservation from issue
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_rd,
  // source hazard lookup
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  // register-file write port
  output logic        rf_we,
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_d,
  // sticky scoreboard protocol error
  output logic        sb_err
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  typedef struct packed {
    logic [IDX_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  pri_e                  pri_q, pri_d;
  logic [NUM_REGS-1:1]   pend_q, pend_d;
  logic [NUM_REGS-1:0]   pend_full;
  logic [NUM_REGS-1:0]   pend_nxt_full;
  wb_req_t               sel;
  logic                  xfer;
  logic                  wr_en_d;
  logic                  rsv_set;
  logic                  rsv_clr_same;
  logic                  err_commit;
  logic                  err_double;
  logic                  err_d;

  // Bit 0 is tied low so index 0 reads as never pending.
  assign pend_full = {pend_q, 1'b0};

  // Combinational grant: a lone requester always wins, contention uses pri.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (a_valid && b_valid) begin
      if (pri_q == PRI_A) begin
        a_ready = 1'b1;
      end else begin
        b_ready = 1'b1;
      end
    end else begin
      a_ready = a_valid;
      b_ready = b_valid;
    end
  end

  // Select the transferring request; writes to x0 are accepted but dropped.
  always_comb begin
    sel     = '0;
    xfer    = 1'b0;
    if (a_valid && a_ready) begin
      xfer     = 1'b1;
      sel.rd   = a_rd;
      sel.data = a_data;
    end else if (b_valid && b_ready) begin
      xfer     = 1'b1;
      sel.rd   = b_rd;
      sel.data = b_data;
    end
    wr_en_d = xfer && (sel.rd != '0);
  end

  // Priority flips to the loser only when both requesters competed.
  always_comb begin
    pri_d = pri_q;
    if (a_valid && b_valid) begin
      pri_d = (pri_q == PRI_A) ? PRI_B : PRI_A;
    end
  end

  // Scoreboard update (commit clears, reservation sets, set wins) and error detection.
  always_comb begin
    rsv_set       = rsv_valid && (rsv_rd != '0);
    rsv_clr_same  = rf_we && (rf_wr == rsv_rd);
    pend_nxt_full = pend_full;
    if (rf_we) begin
      pend_nxt_full[rf_wr] = 1'b0;
    end
    if (rsv_set) begin
      pend_nxt_full[rsv_rd] = 1'b1;
    end
    pend_d     = pend_nxt_full[NUM_REGS-1:1];
    err_commit = rf_we && !pend_full[rf_wr];
    err_double = rsv_set && pend_full[rsv_rd] && !rsv_clr_same;
    err_d      = sb_err || err_commit || err_double;
  end

  // Source busy lookup; a commit this cycle is already visible in the register file.
  always_comb begin
    rs1_busy = pend_full[rs1] && !(rf_we && (rf_wr == rs1));
    rs2_busy = pend_full[rs2] && !(rf_we && (rf_wr == rs2));
  end

  // State registers: write port, scoreboard, priority pointer, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we  <= 1'b0;
      rf_wr  <= '0;
      rf_d   <= '0;
      pend_q <= '0;
      pri_q  <= PRI_A;
      sb_err <= 1'b0;
    end else begin
      rf_we  <= wr_en_d;
      if (wr_en_d) begin
        rf_wr <= sel.rd;
        rf_d  <= sel.data;
      end
      pend_q <= pend_d;
      pri_q  <= pri_d;
      sb_err <= err_d;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed stimulus pushes expected register-file
// writes into a queue; a negedge monitor pops and compares each rf_we cycle.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, rsv_valid;
  logic [4:0]  a_rd, b_rd, rsv_rd, rs1, rs2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, rs1_busy, rs2_busy, rf_we, sb_err;
  logic [4:0]  rf_wr;
  logic [31:0] rf_d;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  // contention table: per-cycle A/B requests and the hand-derived grant
  int          ct_ar [4] = '{1, 3, 3, 0};
  logic [31:0] ct_ad [4] = '{32'hA1, 32'hA3, 32'hA3, 32'hA0};
  int          ct_br [4] = '{2, 2, 4, 4};
  logic [31:0] ct_bd [4] = '{32'hB2, 32'hB2, 32'hB4, 32'hB4};
  int          ct_ga [4] = '{1, 0, 1, 0};
  // priority-hold table: rd=0 transfers only
  int          ph_av [4] = '{1, 1, 1, 1};
  int          ph_bv [4] = '{1, 0, 1, 1};
  int          ph_ga [4] = '{1, 1, 0, 1};
  int          ph_gb [4] = '{0, 0, 1, 0};

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_d(rf_d), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    mid();
    chk("rst_pulse_sb_err", 32'(sb_err), 32'd0);
    step();
    rst = 1'b0;
  endtask

  task automatic reserve(input logic [4:0] rd);
    rsv_valid = 1'b1;
    rsv_rd    = rd;
    step();
    rsv_valid = 1'b0;
    rsv_rd    = 5'd0;
  endtask

  // Monitor: every committed write must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && rf_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: rf_wr=%0d rf_d=%h (t=%0t)", rf_wr, rf_d, $time);
      end else begin
        e = exp_q.pop_front();
        if (rf_wr !== e.rd || rf_d !== e.data) begin
          n_err++;
          $display("FAIL write_port: got rd=%0d d=%h expected rd=%0d d=%h (t=%0t)",
                   rf_wr, rf_d, e.rd, e.data, $time);
        end
      end
    end
    if (a_valid && b_valid) begin
      n_vec++;
      if (a_ready && b_ready) begin
        n_err++;
        $display("FAIL grant_exclusive: a_ready=%b b_ready=%b expected not both (t=%0t)",
                 a_ready, b_ready, $time);
      end
    end
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h1;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'h0;
    rsv_valid = 1'b0; rsv_rd = 5'd0; rs1 = 5'd3; rs2 = 5'd0;

    // reset state, request presented during reset
    mid();
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_wr", 32'(rf_wr), 32'd0);
    chk("rst_rf_d", rf_d, 32'd0);
    chk("rst_sb_err", 32'(sb_err), 32'd0);
    chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);
    step();
    a_valid = 1'b0; a_rd = 5'd0; rst = 1'b0;
    mid();
    chk("post_rst_no_write", 32'(rf_we), 32'd0);
    step();

    // single request with reservation of x5
    rsv_valid = 1'b1; rsv_rd = 5'd5; rs1 = 5'd5;
    mid();
    chk("x5_busy_before_rsv", 32'(rs1_busy), 32'd0);
    step();
    rsv_valid = 1'b0; rsv_rd = 5'd0;
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    mid();
    chk("x5_busy_pending", 32'(rs1_busy), 32'd1);
    chk("x5_a_ready", 32'(a_ready), 32'd1);
    expect_wr(5'd5, 32'hDEADBEEF);
    step();
    a_valid = 1'b0;
    mid();
    chk("x5_commit_we", 32'(rf_we), 32'd1);
    chk("x5_busy_commit", 32'(rs1_busy), 32'd0);
    step();
    mid();
    chk("x5_busy_after", 32'(rs1_busy), 32'd0);
    chk("x5_we_after", 32'(rf_we), 32'd0);
    chk("x5_sb_err", 32'(sb_err), 32'd0);
    step();

    // contention after reset: A,B,A,B
    rst_pulse();
    reserve(5'd1); reserve(5'd2); reserve(5'd3); reserve(5'd4);
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_rd = 5'(ct_ar[i]); a_data = ct_ad[i];
      b_valid = 1'b1; b_rd = 5'(ct_br[i]); b_data = ct_bd[i];
      mid();
      chk($sformatf("cont_a_ready_%0d", i), 32'(a_ready), 32'(ct_ga[i]));
      chk($sformatf("cont_b_ready_%0d", i), 32'(b_ready), 32'(1 - ct_ga[i]));
      if (ct_ga[i] != 0) expect_wr(5'(ct_ar[i]), ct_ad[i]);
      else               expect_wr(5'(ct_br[i]), ct_bd[i]);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    mid();
    chk("cont_sb_err", 32'(sb_err), 32'd0);
    step();

    // priority holds when only one requester is valid (rd=0, no writes)
    a_rd = 5'd0; b_rd = 5'd0;
    for (int i = 0; i < 4; i++) begin
      a_valid = ph_av[i][0]; b_valid = ph_bv[i][0];
      a_data = 32'h100 + 32'(i); b_data = 32'h200 + 32'(i);
      mid();
      chk($sformatf("pri_a_ready_%0d", i), 32'(a_ready), 32'(ph_ga[i]));
      chk($sformatf("pri_b_ready_%0d", i), 32'(b_ready), 32'(ph_gb[i]));
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // x0 write from B
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h1234;
    mid();
    chk("x0_b_ready", 32'(b_ready), 32'd1);
    step();
    b_valid = 1'b0;
    mid();
    chk("x0_rf_we", 32'(rf_we), 32'd0);
    chk("x0_sb_err", 32'(sb_err), 32'd0);
    step();

    // set/clear collision on x7
    reserve(5'd7);
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
    mid();
    expect_wr(5'd7, 32'h77);
    step();
    a_valid = 1'b0;
    rsv_valid = 1'b1; rsv_rd = 5'd7; rs1 = 5'd7;
    mid();
    chk("x7_collide_we", 32'(rf_we), 32'd1);
    chk("x7_busy_commit", 32'(rs1_busy), 32'd0);
    step();
    rsv_valid = 1'b0; rsv_rd = 5'd0;
    mid();
    chk("x7_still_pending", 32'(rs1_busy), 32'd1);
    chk("x7_sb_err", 32'(sb_err), 32'd0);
    step();
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h78;
    mid();
    expect_wr(5'd7, 32'h78);
    step();
    a_valid = 1'b0;
    step();
    mid();
    chk("x7_cleared", 32'(rs1_busy), 32'd0);
    chk("x7_sb_err_final", 32'(sb_err), 32'd0);
    step();

    // commit without reservation sets sticky error
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h99;
    mid();
    expect_wr(5'd9, 32'h99);
    step();
    a_valid = 1'b0;
    mid();
    chk("err9_not_yet", 32'(sb_err), 32'd0);
    step();
    mid();
    chk("err9_set", 32'(sb_err), 32'd1);
    step(); step();
    mid();
    chk("err9_sticky", 32'(sb_err), 32'd1);
    step();
    rst_pulse();
    mid();
    chk("err9_cleared_by_rst", 32'(sb_err), 32'd0);
    step();

    // double reservation of x10
    reserve(5'd10);
    rsv_valid = 1'b1; rsv_rd = 5'd10; rs1 = 5'd10;
    mid();
    chk("dbl_not_yet", 32'(sb_err), 32'd0);
    step();
    rsv_valid = 1'b0; rsv_rd = 5'd0;
    mid();
    chk("dbl_err", 32'(sb_err), 32'd1);
    chk("dbl_pending", 32'(rs1_busy), 32'd1);
    step();
    rst_pulse();

    // asynchronous reset while a write is on the port
    reserve(5'd12);
    reserve(5'd13);
    a_valid = 1'b1; a_rd = 5'd12; a_data = 32'hC0FFEE;
    mid();
    expect_wr(5'd12, 32'hC0FFEE);
    step();
    a_valid = 1'b0; rs2 = 5'd13;
    mid();
    chk("async_pre_we", 32'(rf_we), 32'd1);
    chk("async_pre_busy13", 32'(rs2_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_we", 32'(rf_we), 32'd0);
    chk("async_wr", 32'(rf_wr), 32'd0);
    chk("async_d", rf_d, 32'd0);
    chk("async_busy13", 32'(rs2_busy), 32'd0);
    step();
    rst = 1'b0;
    step(); step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
